// File: rtl/gate_pkg.sv
// Shared types and default parameters for the parking-lot entry gate.
package gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BADGE,
    ST_CHECK,
    ST_OPEN,
    ST_PASSING,
    ST_REPORT,
    ST_REJECT
  } gate_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_LEN       = 3;
  localparam int unsigned DEF_BADGE_TIMEOUT   = 16;
  localparam int unsigned DEF_PASS_TIMEOUT    = 64;

endpackage

// File: rtl/sensor_filter.sv
// Two-flop synchroniser for a raw loop sensor, with an optional debounce
// stage enabled by ENTRY_GATE_DEBOUNCE_EN.
module sensor_filter
  import gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic filt_o
);

  logic [1:0] sync_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("sensor_filter: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

`ifdef ENTRY_GATE_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync_q[1];
`endif

endmodule

// File: rtl/entry_gate_ctrl.sv
// Entry barrier sequencer: badge check, vacancy check, barrier and entry pulse.
// Build option ENTRY_GATE_DEBOUNCE_EN adds debounce to both loop sensors.
module entry_gate_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_LEN       = DEF_PULSE_LEN,
  parameter int unsigned BADGE_TIMEOUT   = DEF_BADGE_TIMEOUT,
  parameter int unsigned PASS_TIMEOUT    = DEF_PASS_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic loop_in,
  input  logic loop_out,
  input  logic badge_valid,
  input  logic badge_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic barrier_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic reject,
  output logic timeout_error
);

  localparam int unsigned BW = $clog2(BADGE_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(PASS_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(PULSE_LEN + 2);

  logic        in_f, out_f;
  logic        in_prev_q, out_prev_q;
  logic        in_rise, out_rise, pulse_hold;
  gate_state_e state_q;
  logic        uni_q, barrier_q, entered_q, entered_uni_q, reject_q, timeout_q;
  logic [BW-1:0] badge_cnt_q;
  logic [PW-1:0] pass_cnt_q;
  logic [LW-1:0] pulse_cnt_q;

  sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop_in_filt (
    .clk(clk), .reset_n(reset_n), .raw_i(loop_in), .filt_o(in_f)
  );

  sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop_out_filt (
    .clk(clk), .reset_n(reset_n), .raw_i(loop_out), .filt_o(out_f)
  );

  assign in_rise    = in_f & ~in_prev_q;
  assign out_rise   = out_f & ~out_prev_q;
  // A pulse that is already high runs to completion even when disabled.
  assign pulse_hold = (state_q == ST_REPORT) && entered_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      in_prev_q     <= 1'b0;
      out_prev_q    <= 1'b0;
      uni_q         <= 1'b0;
      barrier_q     <= 1'b0;
      entered_q     <= 1'b0;
      entered_uni_q <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
      badge_cnt_q   <= '0;
      pass_cnt_q    <= '0;
      pulse_cnt_q   <= '0;
    end else begin
      in_prev_q  <= in_f;
      out_prev_q <= out_f;
      if (!enable) timeout_q <= 1'b0;

      if (!enable && !pulse_hold) begin
        state_q       <= ST_IDLE;
        uni_q         <= 1'b0;
        barrier_q     <= 1'b0;
        entered_q     <= 1'b0;
        entered_uni_q <= 1'b0;
        reject_q      <= 1'b0;
        badge_cnt_q   <= '0;
        pass_cnt_q    <= '0;
        pulse_cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_rise && enable) begin
              state_q     <= ST_WAIT_BADGE;
              badge_cnt_q <= '0;
            end
          end
          ST_WAIT_BADGE: begin
            if (badge_valid) begin
              uni_q       <= badge_uni;
              state_q     <= ST_CHECK;
              badge_cnt_q <= '0;
            end else if (badge_cnt_q >= BW'(BADGE_TIMEOUT - 1)) begin
              uni_q       <= 1'b0;
              state_q     <= ST_CHECK;
              badge_cnt_q <= '0;
            end else begin
              badge_cnt_q <= badge_cnt_q + 1'b1;
            end
          end
          ST_CHECK: begin
            if (uni_q ? uni_is_vacated_space : is_vacated_space) begin
              state_q    <= ST_OPEN;
              barrier_q  <= 1'b1;
              pass_cnt_q <= '0;
            end else begin
              state_q  <= ST_REJECT;
              reject_q <= 1'b1;
            end
          end
          ST_REJECT: begin
            reject_q <= 1'b0;
            if (!in_f) state_q <= ST_IDLE;
          end
          ST_OPEN: begin
            if (out_rise) begin
              state_q    <= ST_PASSING;
              pass_cnt_q <= '0;
            end else if (pass_cnt_q >= PW'(PASS_TIMEOUT - 1)) begin
              state_q    <= ST_IDLE;
              barrier_q  <= 1'b0;
              timeout_q  <= 1'b1;
              pass_cnt_q <= '0;
            end else begin
              pass_cnt_q <= pass_cnt_q + 1'b1;
            end
          end
          ST_PASSING: begin
            if (!out_f) begin
              state_q       <= ST_REPORT;
              barrier_q     <= 1'b0;
              entered_uni_q <= uni_q;
              pulse_cnt_q   <= '0;
            end
          end
          ST_REPORT: begin
            // Class leads the pulse by one cycle and trails it by one cycle.
            if (pulse_cnt_q == LW'(PULSE_LEN + 1)) begin
              state_q       <= ST_IDLE;
              entered_uni_q <= 1'b0;
              pulse_cnt_q   <= '0;
            end else begin
              pulse_cnt_q <= pulse_cnt_q + 1'b1;
              if (pulse_cnt_q == '0) entered_q <= 1'b1;
              else if (pulse_cnt_q == LW'(PULSE_LEN)) entered_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign barrier_open       = barrier_q;
  assign car_entered        = entered_q;
  assign is_uni_car_entered = entered_uni_q;
  assign reject             = reject_q;
  assign timeout_error      = timeout_q;

endmodule

// File: tb/tb_entry_gate_ctrl.sv
// Directed self-checking bench for entry_gate_ctrl with hand-derived timing.
module tb_entry_gate_ctrl;

`ifdef ENTRY_GATE_DEBOUNCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic loop_in = 1'b0;
  logic loop_out = 1'b0;
  logic badge_valid = 1'b0;
  logic badge_uni = 1'b0;
  logic uni_is_vacated_space = 1'b0;
  logic is_vacated_space = 1'b0;
  logic barrier_open, car_entered, is_uni_car_entered, reject, timeout_error;

  int checks = 0;
  int errors = 0;

  entry_gate_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .loop_in(loop_in), .loop_out(loop_out),
    .badge_valid(badge_valid), .badge_uni(badge_uni),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .barrier_open(barrier_open), .car_entered(car_entered),
    .is_uni_car_entered(is_uni_car_entered), .reject(reject),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observes outputs for n cycles and summarises what was seen.
  task automatic watch(input int n, output int ce_hi, output int ce_rise,
                       output int bar_hi, output int rej_hi, output int uni_hi,
                       output logic uni_pre, output logic uni_post);
    logic prev_ce, prev_uni;
    prev_ce = car_entered; prev_uni = is_uni_car_entered;
    ce_hi = 0; ce_rise = 0; bar_hi = 0; rej_hi = 0; uni_hi = 0;
    uni_pre = 1'b0; uni_post = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (car_entered && !prev_ce) begin ce_rise++; uni_pre = prev_uni; end
      if (!car_entered && prev_ce) uni_post = is_uni_car_entered;
      if (car_entered) begin ce_hi++; if (is_uni_car_entered) uni_hi++; end
      if (barrier_open) bar_hi++;
      if (reject) rej_hi++;
      prev_ce = car_entered; prev_uni = is_uni_car_entered;
    end
  endtask

  task automatic admit_other_car();
    loop_in = 1'b1;
    step(3 + EXTRA);
    badge_valid = 1'b1; badge_uni = 1'b0;
    step(1);
    badge_valid = 1'b0;
    step(1);
  endtask

  task automatic settle();
    loop_in = 1'b0; loop_out = 1'b0; badge_valid = 1'b0; enable = 1'b1;
    step(10 + EXTRA);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    step(3);
    checks++; if (barrier_open !== 1'b0) begin errors++; $display("FAIL reset_barrier got %b want 0", barrier_open); end
    checks++; if (car_entered !== 1'b0) begin errors++; $display("FAIL reset_car_entered got %b want 0", car_entered); end
    checks++; if (is_uni_car_entered !== 1'b0) begin errors++; $display("FAIL reset_is_uni got %b want 0", is_uni_car_entered); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset_reject got %b want 0", reject); end
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_error); end
    reset_n = 1'b1;
    enable = 1'b1;
    step(5);
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_uni_entry();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    loop_in = 1'b1;
    step(3 + EXTRA);
    badge_valid = 1'b1; badge_uni = 1'b1;
    step(1);
    badge_valid = 1'b0; badge_uni = 1'b0;
    checks++; if (barrier_open !== 1'b0) begin errors++; $display("FAIL uni_check_cycle barrier got %b want 0", barrier_open); end
    step(1);
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL uni_open barrier got %b want 1", barrier_open); end
    loop_out = 1'b1;
    step(6 + EXTRA);
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL uni_passing barrier got %b want 1", barrier_open); end
    loop_out = 1'b0; loop_in = 1'b0;
    watch(25 + EXTRA, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (ce_hi !== 3) begin errors++; $display("FAIL uni_pulse_len got %0d want 3", ce_hi); end
    checks++; if (ce_rise !== 1) begin errors++; $display("FAIL uni_pulse_count got %0d want 1", ce_rise); end
    checks++; if (uni_hi !== 3) begin errors++; $display("FAIL uni_class_during got %0d want 3", uni_hi); end
    checks++; if (uni_pre !== 1'b1) begin errors++; $display("FAIL uni_class_before got %b want 1", uni_pre); end
    checks++; if (uni_post !== 1'b1) begin errors++; $display("FAIL uni_class_after got %b want 1", uni_post); end
    checks++; if (barrier_open !== 1'b0) begin errors++; $display("FAIL uni_barrier_closed got %b want 0", barrier_open); end
    $display("test_uni_entry: pulse_cycles=%0d pulses=%0d", ce_hi, ce_rise);
    settle();
  endtask

  task automatic test_reject();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    loop_in = 1'b1;
    step(3 + EXTRA);
    badge_valid = 1'b1; badge_uni = 1'b0;
    step(1);
    badge_valid = 1'b0;
    watch(10, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (rej_hi !== 1) begin errors++; $display("FAIL reject_len got %0d want 1", rej_hi); end
    checks++; if (bar_hi !== 0) begin errors++; $display("FAIL reject_barrier got %0d want 0", bar_hi); end
    checks++; if (ce_hi !== 0) begin errors++; $display("FAIL reject_pulse got %0d want 0", ce_hi); end
    $display("test_reject: reject_cycles=%0d", rej_hi);
    settle();
  endtask

  task automatic test_badge_timeout();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    loop_in = 1'b1;
    badge_valid = 1'b1; badge_uni = 1'b1;
    step(1);
    badge_valid = 1'b0; badge_uni = 1'b0;
    step(18 + EXTRA);
    checks++; if (barrier_open !== 1'b0) begin errors++; $display("FAIL badge_to_early barrier got %b want 0", barrier_open); end
    step(1);
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL badge_to_open barrier got %b want 1", barrier_open); end
    loop_out = 1'b1;
    step(4 + EXTRA);
    loop_out = 1'b0; loop_in = 1'b0;
    watch(25 + EXTRA, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (ce_hi !== 3) begin errors++; $display("FAIL badge_to_pulse_len got %0d want 3", ce_hi); end
    checks++; if (uni_hi !== 0) begin errors++; $display("FAIL badge_to_class got %0d want 0", uni_hi); end
    checks++; if (uni_pre !== 1'b0) begin errors++; $display("FAIL badge_to_class_before got %b want 0", uni_pre); end
    $display("test_badge_timeout: pulse_cycles=%0d uni_cycles=%0d", ce_hi, uni_hi);
    settle();
  endtask

  task automatic test_early_badge();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    loop_in = 1'b1;
    step(2 + EXTRA);
    badge_valid = 1'b1; badge_uni = 1'b1;
    step(1);
    badge_valid = 1'b0; badge_uni = 1'b0;
    watch(25, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (rej_hi !== 1) begin errors++; $display("FAIL early_badge_reject got %0d want 1", rej_hi); end
    checks++; if (bar_hi !== 0) begin errors++; $display("FAIL early_badge_barrier got %0d want 0", bar_hi); end
    $display("test_early_badge: reject_cycles=%0d barrier_cycles=%0d", rej_hi, bar_hi);
    settle();
  endtask

  task automatic test_pass_timeout();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    admit_other_car();
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL pass_to_open barrier got %b want 1", barrier_open); end
    step(63);
    checks++; if (barrier_open !== 1'b1 || timeout_error !== 1'b0) begin errors++; $display("FAIL pass_to_early barrier=%b timeout=%b want 1 0", barrier_open, timeout_error); end
    step(1);
    checks++; if (barrier_open !== 1'b0 || timeout_error !== 1'b1) begin errors++; $display("FAIL pass_to_fire barrier=%b timeout=%b want 0 1", barrier_open, timeout_error); end
    watch(10, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (ce_hi !== 0) begin errors++; $display("FAIL pass_to_pulse got %0d want 0", ce_hi); end
    loop_in = 1'b0;
    step(5 + EXTRA);
    checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout_error); end
    enable = 1'b0;
    step(1);
    checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout_error); end
    $display("test_pass_timeout: timeout raised and cleared by enable");
    settle();
  endtask

  task automatic test_enable_abort();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    admit_other_car();
    enable = 1'b0;
    step(1);
    checks++; if (barrier_open !== 1'b0) begin errors++; $display("FAIL abort_barrier got %b want 0", barrier_open); end
    enable = 1'b1;
    loop_out = 1'b1;
    step(4 + EXTRA);
    loop_out = 1'b0; loop_in = 1'b0;
    watch(20 + EXTRA, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (ce_hi !== 0 || bar_hi !== 0) begin errors++; $display("FAIL abort_no_pulse pulse=%0d barrier=%0d want 0 0", ce_hi, bar_hi); end
    $display("test_enable_abort: pulse_cycles=%0d", ce_hi);
    settle();
  endtask

  task automatic test_pulse_completes();
    int ce_hi;
    bit dropped;
    ce_hi = 0; dropped = 1'b0;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    admit_other_car();
    loop_out = 1'b1;
    step(4 + EXTRA);
    loop_out = 1'b0; loop_in = 1'b0;
    for (int i = 0; i < 30 + EXTRA; i++) begin
      @(negedge clk);
      if (car_entered) begin
        ce_hi++;
        if (!dropped) begin enable = 1'b0; dropped = 1'b1; end
      end
    end
    checks++; if (ce_hi !== 3) begin errors++; $display("FAIL pulse_completes got %0d want 3", ce_hi); end
    $display("test_pulse_completes: pulse_cycles=%0d", ce_hi);
    settle();
  endtask

  task automatic test_reset_mid();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    admit_other_car();
    loop_out = 1'b1;
    step(4 + EXTRA);
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL midrst_passing barrier got %b want 1", barrier_open); end
    loop_in = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({barrier_open, car_entered, is_uni_car_entered, reject, timeout_error} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs got %b want 00000", {barrier_open, car_entered, is_uni_car_entered, reject, timeout_error});
    end
    step(2);
    reset_n = 1'b1;
    step(2);
    loop_out = 1'b0;
    watch(20 + EXTRA, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (ce_hi !== 0 || bar_hi !== 0) begin errors++; $display("FAIL midrst_no_pulse pulse=%0d barrier=%0d want 0 0", ce_hi, bar_hi); end
    $display("test_reset_mid: pulse_cycles=%0d", ce_hi);
    settle();
  endtask

`ifdef ENTRY_GATE_DEBOUNCE_EN
  task automatic test_debounce();
    int ce_hi, ce_rise, bar_hi, rej_hi, uni_hi;
    logic uni_pre, uni_post;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    loop_in = 1'b1;
    step(2);
    loop_in = 1'b0;
    watch(30, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (bar_hi !== 0) begin errors++; $display("FAIL debounce_glitch barrier=%0d want 0", bar_hi); end
    loop_in = 1'b1;
    watch(30, ce_hi, ce_rise, bar_hi, rej_hi, uni_hi, uni_pre, uni_post);
    checks++; if (barrier_open !== 1'b1) begin errors++; $display("FAIL debounce_steady barrier got %b want 1", barrier_open); end
    $display("test_debounce: glitch ignored, steady level accepted");
    enable = 1'b0;
    step(1);
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_uni_entry();
    test_reject();
    test_badge_timeout();
    test_early_badge();
    test_pass_timeout();
    test_enable_abort();
    test_pulse_completes();
    test_reset_mid();
`ifdef ENTRY_GATE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/entry_gate_ctrl.md
ENTRY_GATE_CTRL -- requirements
Module: entry_gate_ctrl

Interface
REQ-001 The block SHALL have these parameters: DEBOUNCE_CYCLES, default 4, consecutive equal samples needed to accept a loop-sensor level.
REQ-002 The block SHALL have these parameters: PULSE_LEN, default 3, number of clk cycles car_entered is held high.
REQ-003 The block SHALL have these parameters: BADGE_TIMEOUT, default 16, cycles allowed from car detection to badge_valid.
REQ-004 The block SHALL have these parameters: PASS_TIMEOUT, default 64, cycles allowed from barrier open to the car passing.
REQ-005 The block SHALL have a single clock, clk; reset is asynchronous and active-low, reset_n.
REQ-006 The ports SHALL be, clock and reset first:
- clk in 1: clock.
- reset_n in 1: async active-low reset.
- enable in 1: gate in service.
- loop_in in 1: raw vehicle-at-gate sensor, asynchronous.
- loop_out in 1: raw vehicle-past-barrier sensor, asynchronous.
- badge_valid in 1: one-cycle badge read strobe.
- badge_uni in 1: badge class, 1 = university, sampled with badge_valid.
- uni_is_vacated_space in 1: downstream university vacancy.
- is_vacated_space in 1: downstream other vacancy.
- barrier_open out 1: barrier actuator.
- car_entered out 1: entry pulse; the downstream block acts on its falling edge.
- is_uni_car_entered out 1: class of the reported car.
- reject out 1: lot full, one cycle.
- timeout_error out 1: sticky fault flag.

Function
REQ-007 loop_in and loop_out SHALL each pass a 2-flop synchroniser before any use.
REQ-008 The FSM SHALL be IDLE -> WAIT_BADGE -> CHECK -> OPEN -> PASSING -> REPORT -> IDLE, plus a REJECT state.
REQ-009 IDLE SHALL go to WAIT_BADGE when the filtered loop_in rises and enable=1.
REQ-010 WAIT_BADGE SHALL latch badge_uni on badge_valid and go to CHECK; after BADGE_TIMEOUT cycles without badge_valid it SHALL treat the car as non-university and go to CHECK.
REQ-011 CHECK SHALL last one cycle and go to OPEN if the vacancy flag for the latched class is 1, else to REJECT.
REQ-012 REJECT SHALL assert reject for exactly one cycle, then hold barrier closed until filtered loop_in falls, then go to IDLE.
REQ-013 OPEN SHALL drive barrier_open=1 and go to PASSING when filtered loop_out rises.
REQ-014 In OPEN, if PASS_TIMEOUT cycles expire first, timeout_error SHALL set, barrier_open SHALL drop, and the FSM SHALL go to IDLE with no pulse.
REQ-015 PASSING SHALL keep barrier_open=1 until filtered loop_out falls, then go to REPORT.
REQ-016 REPORT SHALL drive car_entered=1 for exactly PULSE_LEN cycles, with is_uni_car_entered stable from one cycle before the rising edge until one cycle after the falling edge, then go to IDLE.
REQ-017 At most one car_entered pulse SHALL be generated per vehicle, and badge_valid outside WAIT_BADGE SHALL be ignored.
REQ-018 enable=0 in any state SHALL abort to IDLE on the next clk, drop barrier_open, and suppress any pending pulse; a pulse already high SHALL complete.
REQ-019 Timeout counters SHALL be sized by $clog2 of their parameter+1, saturate, and clear on every state entry.
REQ-020 timeout_error SHALL clear only on reset or when enable goes 0.

Reset
REQ-021 Asserting reset_n=0 SHALL immediately force state=IDLE and barrier_open=0, car_entered=0, is_uni_car_entered=0, reject=0, timeout_error=0, clear all counters, and clear synchroniser/filter flops to 0.
REQ-022 Reset deassertion mid-vehicle SHALL not produce a pulse until a fresh loop_in rise.

Configuration
REQ-023 With ENTRY_GATE_DEBOUNCE_EN defined, each synchronised sensor SHALL pass a filter that changes its output only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-024 Without ENTRY_GATE_DEBOUNCE_EN, the filtered sensor SHALL equal the synchroniser output, which gives 2-cycle sensor latency.

Structure
REQ-025 A shared package gate_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-026 A sub-module sensor_filter (synchroniser plus optional debounce) SHALL be instantiated once per loop sensor.

Verification
REQ-027 University badge with uni_is_vacated_space=1, then loop_out pulse -> barrier_open, then 3-cycle car_entered with is_uni_car_entered=1.
REQ-028 Other car with is_vacated_space=0 -> reject high for 1 cycle, barrier_open never 1, no car_entered.
REQ-029 No badge within 16 cycles, is_vacated_space=1 -> car treated as other, car_entered pulse with is_uni_car_entered=0.
REQ-030 Barrier open with loop_out absent for 64 cycles -> timeout_error=1, barrier_open=0, no pulse.
REQ-031 With debounce on, a 2-cycle loop_in glitch -> FSM stays in IDLE; a 4-cycle steady high -> WAIT_BADGE.
REQ-032 reset_n low during PASSING -> all outputs 0 immediately, and no pulse after release.
